// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared constants, widths and FSM encoding for the wave scheduler
// Contents:
//   size/logsize/acc_width defaults, channel codes, scheduler state enum
package wave_pkg;

    localparam int SIZE_DEF      = 12;
    localparam int LOGSIZE_DEF   = 10;
    localparam int ACC_WIDTH_DEF = 24;

    localparam logic CH_SINE = 1'b0;
    localparam logic CH_TRI  = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ_A = 2'd1,
        REQ_B = 2'd2,
        CAP_B = 2'd3
    } wave_state_e;

endpackage

// File: rtl/wave_scheduler_if.sv
// rtl/wave_scheduler_if.sv - waveform memory port shared by scheduler (master) and memory (slave)
// Signals:
//   mem_read     read strobe
//   mem_channel  table select (CH_SINE / CH_TRI)
//   mem_address  table address
//   mem_sample   read data, valid the cycle after mem_read
interface wave_scheduler_if
    import wave_pkg::*;
#(
    parameter int size    = SIZE_DEF,
    parameter int logsize = LOGSIZE_DEF
);

    logic               mem_read;
    logic               mem_channel;
    logic [logsize-1:0] mem_address;
    logic [size-1:0]    mem_sample;

    modport master (
        output mem_read,
        output mem_channel,
        output mem_address,
        input  mem_sample
    );

    modport slave (
        input  mem_read,
        input  mem_channel,
        input  mem_address,
        output mem_sample
    );

endinterface

// File: rtl/phase_acc.sv
// rtl/phase_acc.sv - one voice phase accumulator with step snapshot and sync handling
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   start      accepted tick: capture step_in for this sequence
//   idle       scheduler is idle (sync applies immediately)
//   advance    last cycle of the sequence (increment or deferred clear)
//   sync       phase reset request
//   step_in    tuning word
//   addr       table address = top logsize bits of the accumulator
module phase_acc
    import wave_pkg::*;
#(
    parameter int acc_width = ACC_WIDTH_DEF,
    parameter int logsize   = LOGSIZE_DEF
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 idle,
    input  logic                 advance,
    input  logic                 sync,
    input  logic [acc_width-1:0] step_in,
    output logic [logsize-1:0]   addr
);

    logic [acc_width-1:0] acc_q, acc_d;
    logic [acc_width-1:0] step_q, step_d;
    logic                 sync_pend_q, sync_pend_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            step_q      <= '0;
            sync_pend_q <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            step_q      <= step_d;
            sync_pend_q <= sync_pend_d;
        end
    end

    always_comb begin
        acc_d       = acc_q;
        step_d      = start ? step_in : step_q;
        sync_pend_d = sync_pend_q;
        if (idle) begin
            // Clearing here also covers sync arriving together with the tick,
            // so that sequence reads address 0.
            if (sync) begin
                acc_d = '0;
            end
        end else if (advance) begin
            // A sync seen at any point of the sequence replaces the increment.
            acc_d       = (sync_pend_q || sync) ? '0 : acc_q + step_q;
            sync_pend_d = 1'b0;
        end else if (sync) begin
            sync_pend_d = 1'b1;
        end
    end

    assign addr = acc_q[acc_width-1 -: logsize];

endmodule

// File: rtl/wave_scheduler.sv
// rtl/wave_scheduler.sv - time-multiplexes the shared waveform memory between voices A and B
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   enable, tick        tick accepted only when enable=1 and idle
//   sync                phase reset for both accumulators
//   step_a/b, wave_a/b  tuning words and table selects, snapshotted per tick
//   overrun_clr         clears sticky overrun (a same-cycle set wins)
//   mem                 memory port (master modport)
//   sample_a/b          held samples, valid_a/b single-cycle update pulses
//   busy, overrun       not idle / tick arrived while busy
module wave_scheduler
    import wave_pkg::*;
#(
    parameter int size      = SIZE_DEF,
    parameter int logsize   = LOGSIZE_DEF,
    parameter int acc_width = ACC_WIDTH_DEF
)
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 tick,
    input  logic                 sync,
    input  logic [acc_width-1:0] step_a,
    input  logic [acc_width-1:0] step_b,
    input  logic                 wave_a,
    input  logic                 wave_b,
    input  logic                 overrun_clr,
    wave_scheduler_if.master     mem,
    output logic [size-1:0]      sample_a,
    output logic [size-1:0]      sample_b,
    output logic                 valid_a,
    output logic                 valid_b,
    output logic                 busy,
    output logic                 overrun
);

    wave_state_e state_q, state_d;

    logic               wave_a_q, wave_a_d;
    logic               wave_b_q, wave_b_d;
    logic               chan_q, chan_d;
    logic [logsize-1:0] addr_q, addr_d;
    logic [size-1:0]    sample_a_q, sample_a_d;
    logic [size-1:0]    sample_b_q, sample_b_d;
    logic               valid_a_q, valid_a_d;
    logic               valid_b_q, valid_b_d;
    logic               overrun_q, overrun_d;

    logic               accept;
    logic               idle;
    logic               advance;
    logic [logsize-1:0] addr_a;
    logic [logsize-1:0] addr_b;

    assign idle    = (state_q == IDLE);
    assign advance = (state_q == CAP_B);
    assign accept  = idle && tick && enable;

    phase_acc #(.acc_width(acc_width), .logsize(logsize)) u_acc_a (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .idle    (idle),
        .advance (advance),
        .sync    (sync),
        .step_in (step_a),
        .addr    (addr_a)
    );

    phase_acc #(.acc_width(acc_width), .logsize(logsize)) u_acc_b (
        .clk     (clk),
        .rst     (rst),
        .start   (accept),
        .idle    (idle),
        .advance (advance),
        .sync    (sync),
        .step_in (step_b),
        .addr    (addr_b)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: fixed four-cycle walk, no stalls
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = REQ_A;
            REQ_A:   state_d = REQ_B;
            REQ_B:   state_d = CAP_B;
            CAP_B:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: address/channel fall back to the held copy outside the read states
    always_comb begin
        mem.mem_read    = 1'b0;
        mem.mem_channel = chan_q;
        mem.mem_address = addr_q;
        busy            = !idle;
        case (state_q)
            REQ_A: begin
                mem.mem_read    = 1'b1;
                mem.mem_channel = wave_a_q ? CH_TRI : CH_SINE;
                mem.mem_address = addr_a;
            end
            REQ_B: begin
                mem.mem_read    = 1'b1;
                mem.mem_channel = wave_b_q ? CH_TRI : CH_SINE;
                mem.mem_address = addr_b;
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wave_a_q   <= CH_SINE;
            wave_b_q   <= CH_SINE;
            chan_q     <= CH_SINE;
            addr_q     <= '0;
            sample_a_q <= '0;
            sample_b_q <= '0;
            valid_a_q  <= 1'b0;
            valid_b_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            wave_a_q   <= wave_a_d;
            wave_b_q   <= wave_b_d;
            chan_q     <= chan_d;
            addr_q     <= addr_d;
            sample_a_q <= sample_a_d;
            sample_b_q <= sample_b_d;
            valid_a_q  <= valid_a_d;
            valid_b_q  <= valid_b_d;
            overrun_q  <= overrun_d;
        end
    end

    always_comb begin
        wave_a_d   = accept ? wave_a : wave_a_q;
        wave_b_d   = accept ? wave_b : wave_b_q;
        chan_d     = mem.mem_channel;
        addr_d     = mem.mem_address;
        // Read data returns one cycle after the request: A's data is on the
        // bus during REQ_B, B's during CAP_B.
        sample_a_d = (state_q == REQ_B) ? mem.mem_sample : sample_a_q;
        sample_b_d = (state_q == CAP_B) ? mem.mem_sample : sample_b_q;
        valid_a_d  = (state_q == REQ_B);
        valid_b_d  = (state_q == CAP_B);
        if (tick && enable && !idle) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end
    end

    assign sample_a = sample_a_q;
    assign sample_b = sample_b_q;
    assign valid_a  = valid_a_q;
    assign valid_b  = valid_b_q;
    assign overrun  = overrun_q;

endmodule
